scan_chain_responder: RTL and testbench
=======================================

// Module: scan_chain_responder
// PURPOSE
//  CUT-side end of the BIST scan protocol: a CHAIN_LEN-bit scan chain wrapper driven by the
//  BIST controller's scanmode/sdi and returning sdo into its MISR path.
//  - Shifts while scanmode=1.
//  - Captures the CUT functional response on the first scanmode=0 cycle after a shift burst.
//  - Flags protocol violations: burst length != CHAIN_LEN.
// PARAMETERS
//  CHAIN_LEN  228  scan chain length in flops
//  CNT_W      8    shift-counter width; must satisfy 2^CNT_W > CHAIN_LEN
//  CAP_W      16   capture-counter width
// PORTS
//  clk            in   1          rising-edge clock, single clock domain
//  rst            in   1          asynchronous, active-high reset
//  scanmode       in   1          1=shift, 0=capture/hold (from BIST controller)
//  sdi            in   1          serial scan data in
//  sdo            out  1          serial scan data out = chain[CHAIN_LEN-1], registered
//  func_resp      in   CHAIN_LEN  CUT combinational response, sampled on capture
//  func_stim      out  CHAIN_LEN  chain contents driving CUT inputs
//  capture_count  out  CAP_W      number of captures since reset, saturating
//  shift_err      out  1          sticky: some burst length != CHAIN_LEN
//  chain_ready    out  1          1 in the cycle after a correct-length capture
// BEHAVIOUR
//  Reset (async, any state): chain=0, sdo=0, func_stim=0, capture_count=0, shift_err=0,
//    chain_ready=0, shift_cnt=0, state=IDLE. Takes effect mid-shift with no partial capture.
//  FSM states: IDLE, SHIFT, CAPTURE, HOLD.
//   IDLE:    scanmode=1 -> SHIFT (this cycle shifts, shift_cnt=1); else stay, chain held.
//   SHIFT:   scanmode=1 -> stay, shift, shift_cnt+1 (saturates at 2^CNT_W-1);
//            scanmode=0 -> CAPTURE (this cycle performs the capture).
//   CAPTURE: single cycle. chain<=func_resp; capture_count+1 (saturating);
//            shift_err|=(shift_cnt!=CHAIN_LEN); chain_ready<=(shift_cnt==CHAIN_LEN);
//            shift_cnt<=0. Next: scanmode=1 -> SHIFT (shifts this cycle), else HOLD.
//   HOLD:    scanmode=0 -> stay, chain unchanged, no recapture; scanmode=1 -> SHIFT.
//  Shift op: chain<={chain[CHAIN_LEN-2:0],sdi}. sdo is chain[CHAIN_LEN-1] after the edge,
//    so the first captured response bit appears on sdo with 0 cycles latency after capture.
//  Timing:
//   - 1-cycle scanmode=0 between bursts (controller EVAL_PAT) = exactly one capture.
//   - Multi-cycle low (controller DONE/INIT) = one capture, then HOLD.
//   - Burst length counts only scanmode=1 cycles since the last capture.
//   - First burst after reset with no prior capture: the capture is still checked.
//  chain_ready deasserts on the first shift cycle after it was set.
//  shift_err clears only on rst.
//  func_stim = chain at all times; while scanmode=1 the CUT sees a moving pattern (by design).
//  Simultaneous scanmode edge and rst: rst wins.
// STRUCTURE
//  scan_pkg:
//   - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, CAPTURE=2'd2, HOLD=2'd3)
//   - default CHAIN_LEN=228, shared with the BIST controller
//  Sub-module scan_shift_reg (CHAIN_LEN):
//   - chain flops with 3-way mux: shift / load func_resp / hold
//   - async reset to 0
//   - outputs the chain vector and sdo
//  Top: FSM, shift counter, capture counter, error/ready flags.
// TESTING
//  1 reset: assert rst mid-burst (shift_cnt=100)
//    -> all outputs 0 same cycle; state IDLE; following burst counted from 1.
//  2 nominal: 228 shifts of sdi=1, 1 low cycle with func_resp=228'h5A..A5
//    -> chain=all 1s pre-capture; capture_count=1; shift_err=0; chain_ready=1;
//       next 228 shifts put func_resp MSB-first on sdo.
//  3 short/long burst: 227 shifts + capture -> shift_err=1;
//    then 229 shifts + capture -> shift_err stays 1; chain_ready=0 after both.
//  4 hold: 228 shifts, then scanmode=0 for 5 cycles while func_resp changes each cycle
//    -> exactly one capture (first-cycle value kept); capture_count=1.
//  5 loopback with BIST controller: 3 patterns, func_resp=~func_stim
//    -> capture_count=3, shift_err=0, MISR signature repeats across two runs.
//  6 saturation: CAP_W=2, 5 correct captures -> capture_count stays 3, no wrap.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the CUT-side scan chain responder.
// The chain length default is shared with the BIST controller.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int DEFAULT_CHAIN_LEN = 228;

endpackage

// File: rtl/scan_shift_reg.sv
// Scan chain flops: shift from sdi, parallel load of the CUT response, or hold.
module scan_shift_reg #(
  parameter int CHAIN_LEN = 228
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 load_en,
  input  logic                 sdi,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic [CHAIN_LEN-1:0] chain,
  output logic                 sdo
);

  // Chain register; shift and load are never requested together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else if (load_en) begin
      chain <= load_data;
    end else if (shift_en) begin
      chain <= {chain[CHAIN_LEN-2:0], sdi};
    end else begin
      chain <= chain;
    end
  end

  assign sdo = chain[CHAIN_LEN-1];

endmodule

// File: rtl/scan_chain_responder.sv
// CUT-side end of the BIST scan protocol: shifts while scanmode=1, captures the
// CUT response on the first low cycle after a burst, and checks burst length.
module scan_chain_responder
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int CNT_W     = 8,
  parameter int CAP_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scanmode,
  input  logic                 sdi,
  output logic                 sdo,
  input  logic [CHAIN_LEN-1:0] func_resp,
  output logic [CHAIN_LEN-1:0] func_stim,
  output logic [CAP_W-1:0]     capture_count,
  output logic                 shift_err,
  output logic                 chain_ready
);

  state_t           state;
  logic [CNT_W-1:0] shift_cnt;
  logic             load_en;
  logic             burst_ok;

  // Capture fires only on the first low cycle that follows a shift burst.
  assign load_en  = (state == SHIFT) && !scanmode;
  assign burst_ok = (shift_cnt == CNT_W'(CHAIN_LEN));

  scan_shift_reg #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_chain (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (scanmode),
    .load_en   (load_en),
    .sdi       (sdi),
    .load_data (func_resp),
    .chain     (func_stim),
    .sdo       (sdo)
  );

  // Protocol FSM with burst counter, capture counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shift_cnt     <= '0;
      capture_count <= '0;
      shift_err     <= 1'b0;
      chain_ready   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, CAPTURE, HOLD: begin
          if (scanmode) begin
            state       <= SHIFT;
            shift_cnt   <= CNT_W'(1);
            chain_ready <= 1'b0;
          end else if (state == CAPTURE) begin
            state <= HOLD;
          end else begin
            state <= state;
          end
        end
        SHIFT: begin
          if (scanmode) begin
            if (shift_cnt != {CNT_W{1'b1}}) begin
              shift_cnt <= shift_cnt + CNT_W'(1);
            end else begin
              shift_cnt <= shift_cnt;
            end
            chain_ready <= 1'b0;
          end else begin
            state       <= CAPTURE;
            shift_cnt   <= '0;
            shift_err   <= shift_err | !burst_ok;
            chain_ready <= burst_ok;
            if (capture_count != {CAP_W{1'b1}}) begin
              capture_count <= capture_count + CAP_W'(1);
            end else begin
              capture_count <= capture_count;
            end
          end
        end
        default: begin
          state     <= IDLE;
          shift_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_responder.sv
// Randomized bench for scan_chain_responder with a behavioural protocol model
// compared on every falling edge, plus literal checks for the directed scenarios.
module tb_scan_chain_responder;
  localparam int L = 228;

  logic         clk = 1'b0;
  logic         rst;
  logic         scanmode, sdi;
  logic [L-1:0] func_resp;
  logic         sdo;
  logic [L-1:0] func_stim;
  logic [15:0]  capture_count;
  logic         shift_err, chain_ready;

  logic         s_mode, s_sdi;
  logic [7:0]   s_resp, s_stim;
  logic         s_sdo, s_err, s_ready;
  logic [1:0]   s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_chain_responder #(.CHAIN_LEN(L), .CNT_W(8), .CAP_W(16)) dut (
    .clk(clk), .rst(rst), .scanmode(scanmode), .sdi(sdi), .sdo(sdo),
    .func_resp(func_resp), .func_stim(func_stim), .capture_count(capture_count),
    .shift_err(shift_err), .chain_ready(chain_ready)
  );

  scan_chain_responder #(.CHAIN_LEN(8), .CNT_W(4), .CAP_W(2)) dut_sat (
    .clk(clk), .rst(rst), .scanmode(s_mode), .sdi(s_sdi), .sdo(s_sdo),
    .func_resp(s_resp), .func_stim(s_stim), .capture_count(s_cnt),
    .shift_err(s_err), .chain_ready(s_ready)
  );

  // Behavioural model: chain contents, length of the current burst, capture bookkeeping.
  logic [L-1:0] m_chain;
  int           m_burst;
  bit           m_in_burst;
  int           m_caps;
  bit           m_err, m_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_chain <= '0; m_burst <= 0; m_in_burst <= 1'b0;
      m_caps <= 0; m_err <= 1'b0; m_ready <= 1'b0;
    end else if (scanmode) begin
      m_chain    <= {m_chain[L-2:0], sdi};
      m_burst    <= m_burst + 1;
      m_in_burst <= 1'b1;
      m_ready    <= 1'b0;
    end else if (m_in_burst) begin
      m_chain    <= func_resp;
      m_caps     <= (m_caps < 65535) ? m_caps + 1 : m_caps;
      m_err      <= m_err || (m_burst != L);
      m_ready    <= (m_burst == L);
      m_burst    <= 0;
      m_in_burst <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("sdo",           L'(sdo),           L'(m_chain[L-1]));
      check("func_stim",     func_stim,         m_chain);
      check("capture_count", L'(capture_count), L'(m_caps));
      check("shift_err",     L'(shift_err),     L'(m_err));
      check("chain_ready",   L'(chain_ready),   L'(m_ready));
    end
  end

  function automatic logic [L-1:0] rvec();
    logic [L-1:0] v;
    for (int i = 0; i < L; i++) v[i] = 1'($urandom_range(1, 0));
    return v;
  endfunction

  task automatic cyc(input logic sm, input logic d, input logic [L-1:0] r);
    scanmode  = sm;
    sdi       = d;
    func_resp = r;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_shifts(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(1, 0)), rvec());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [L-1:0] pat, ones, first_resp;
  logic [L-1:0] lb [3];
  logic [15:0]  dsig, msig, sig_run1;

  initial begin
    pat  = {8'h5A, {53{4'hC}}, 8'hA5};
    ones = '1;
    rst = 1'b1; scanmode = 1'b0; sdi = 1'b0; func_resp = '0;
    s_mode = 1'b0; s_sdi = 1'b0; s_resp = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_count", L'(capture_count), L'(0));
    check("reset_stim",  func_stim,         L'(0));

    // Reset in the middle of a 100-cycle burst
    rand_shifts(100);
    #3 rst = 1'b1;
    #1;
    check("midrst_stim",  func_stim,         L'(0));
    check("midrst_sdo",   L'(sdo),           L'(0));
    check("midrst_ready", L'(chain_ready),   L'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Nominal burst of ones, then capture of the fixed pattern
    for (int i = 0; i < L; i++) cyc(1'b1, 1'b1, rvec());
    check("nom_pre_stim", func_stim, ones);
    cyc(1'b0, 1'b0, pat);
    check("nom_count", L'(capture_count), L'(1));
    check("nom_err",   L'(shift_err),     L'(0));
    check("nom_ready", L'(chain_ready),   L'(1));
    check("nom_stim",  func_stim,         pat);
    check("nom_sdo0",  L'(sdo),           L'(0));
    cyc(1'b1, 1'b0, rvec());
    check("nom_sdo1",  L'(sdo),           L'(1));
    check("nom_ready_clr", L'(chain_ready), L'(0));
    rand_shifts(L - 1);
    cyc(1'b0, 1'b0, rvec());
    check("nom_count2", L'(capture_count), L'(2));

    // Short then long burst
    rand_shifts(L - 1);
    cyc(1'b0, 1'b0, rvec());
    check("short_err",   L'(shift_err),   L'(1));
    check("short_ready", L'(chain_ready), L'(0));
    rand_shifts(L + 1);
    cyc(1'b0, 1'b0, rvec());
    check("long_err",   L'(shift_err),     L'(1));
    check("long_ready", L'(chain_ready),   L'(0));
    check("long_count", L'(capture_count), L'(4));

    // Long low period: only the first low cycle captures
    rand_shifts(L);
    first_resp = rvec();
    cyc(1'b0, 1'b0, first_resp);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, rvec());
    check("hold_stim",  func_stim,         first_resp);
    check("hold_count", L'(capture_count), L'(5));
    check("hold_ready", L'(chain_ready),   L'(1));

    // Loopback: func_resp = ~func_stim, two identical runs from reset
    for (int p = 0; p < 3; p++) lb[p] = rvec();
    for (int run = 0; run < 2; run++) begin
      do_reset();
      dsig = 16'h0000; msig = 16'h0000;
      for (int p = 0; p < 3; p++) begin
        for (int i = 0; i < L; i++) begin
          cyc(1'b1, lb[p][i], rvec());
          dsig = {dsig[14:0], 1'b0} ^ (dsig[15] ? 16'h1021 : 16'h0000) ^ {15'h0000, sdo};
          msig = {msig[14:0], 1'b0} ^ (msig[15] ? 16'h1021 : 16'h0000) ^ {15'h0000, m_chain[L-1]};
        end
        cyc(1'b0, 1'b0, ~func_stim);
      end
      check("loop_count", L'(capture_count), L'(3));
      check("loop_err",   L'(shift_err),     L'(0));
      check("loop_sig",   L'(dsig),          L'(msig));
      if (run == 0) sig_run1 = msig;
      else check("loop_repeat", L'(dsig), L'(sig_run1));
    end

    // Saturating capture counter on a 2-bit, 8-flop instance
    scanmode = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 8; i++) begin
        s_mode = 1'b1; s_sdi = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
      end
      s_mode = 1'b0; s_resp = 8'($urandom_range(255, 0));
      @(posedge clk); #1;
      check("sat_count", L'(s_cnt),   L'((k < 3) ? k : 3));
      check("sat_err",   L'(s_err),   L'(0));
      check("sat_ready", L'(s_ready), L'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
